// File: rtl/counter_pkg.sv
// Shared constants for the configurable state counter:
// segment bit positions and the hex glyph table.
package counter_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = 7;

    // Active-high glyphs 0-9, A, b, C, d, E, F; bit 0 = segment a.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [SEG_W-1:0] SEG_ALL =
        SEG_W'((1 << (SEG_G + 1)) - (1 << SEG_A));

    function automatic logic [SEG_W-1:0] seg_glyph(
        input logic [3:0] digit
    );
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Hex digit to seven-segment decoder with selectable
// drive polarity.
module hex_to_seven_segment
    import counter_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0]       i_digit,
    output logic [SEG_W-1:0] o_seg
);

    logic [SEG_W-1:0] w_glyph;

    assign w_glyph = seg_glyph(i_digit);
    assign o_seg   = ACTIVE_LOW ? (w_glyph ^ SEG_ALL) : w_glyph;

endmodule

// File: rtl/configurable_state_counter.sv
// Modulo-N up/down counter with load, wrap/saturate modes,
// rollover pulse, limit flag and seven-segment readout.
module configurable_state_counter
    import counter_pkg::*;
#(
    parameter int MODULUS        = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    localparam int W = (MODULUS > 2) ? $clog2(MODULUS) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         up,
    input  logic         wrap,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic [6:0]   seg,
    output logic         rollover,
    output logic         at_limit
);

    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $error("MODULUS must be within 2..16");
    end

    localparam logic [W-1:0] MAX = W'(MODULUS - 1);

    logic [W-1:0] r_count;
    logic         r_rollover;
    logic [W-1:0] w_next;
    logic         w_next_roll;
    logic         w_at_max;
    logic         w_at_zero;

    assign w_at_max  = (r_count == MAX);
    assign w_at_zero = (r_count == '0);

    always_comb begin
        w_next      = r_count;
        w_next_roll = 1'b0;
        if (load) begin
            // Out-of-range loads clamp to the top state.
            w_next = (load_value > MAX) ? MAX : load_value;
        end else if (enable) begin
            if (up) begin
                if (!w_at_max) begin
                    w_next = r_count + W'(1);
                end else if (wrap) begin
                    w_next      = '0;
                    w_next_roll = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_next = r_count - W'(1);
                end else if (wrap) begin
                    w_next      = MAX;
                    w_next_roll = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_rollover <= w_next_roll;
        end
    end

    hex_to_seven_segment #(
        .ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
        .i_digit(4'(r_count)),
        .o_seg  (seg)
    );

    assign count    = r_count;
    assign rollover = r_rollover;
    assign at_limit = up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_configurable_state_counter.sv
// Randomized and directed check of four counter variants
// against a behavioural model of the counting rules.
module tb_configurable_state_counter;

    localparam int NI = 4;
    localparam int MODS [NI] = '{8, 10, 16, 2};
    localparam int WS   [NI] = '{3, 4, 4, 1};
    localparam bit AL   [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};

    localparam bit [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       up     = 1'b1;
    logic       wrap   = 1'b0;
    logic       load   = 1'b0;
    logic [3:0] lv4    = 4'd0;

    logic [2:0] c0;
    logic [3:0] c1, c2;
    logic [0:0] c3;
    logic [6:0] s0, s1, s2, s3;
    logic       r0, r1, r2, r3;
    logic       a0, a1, a2, a3;

    logic [3:0] dc [NI];
    logic [6:0] ds [NI];
    logic       dr [NI];
    logic       da [NI];

    int mcnt  [NI] = '{0, 0, 0, 0};
    bit mroll [NI] = '{0, 0, 0, 0};

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    configurable_state_counter #(.MODULUS(8), .SEG_ACTIVE_LOW(1'b0)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .wrap(wrap), .load(load), .load_value(lv4[2:0]),
        .count(c0), .seg(s0), .rollover(r0), .at_limit(a0));
    configurable_state_counter #(.MODULUS(10), .SEG_ACTIVE_LOW(1'b0)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .wrap(wrap), .load(load), .load_value(lv4),
        .count(c1), .seg(s1), .rollover(r1), .at_limit(a1));
    configurable_state_counter #(.MODULUS(16), .SEG_ACTIVE_LOW(1'b0)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .wrap(wrap), .load(load), .load_value(lv4),
        .count(c2), .seg(s2), .rollover(r2), .at_limit(a2));
    configurable_state_counter #(.MODULUS(2), .SEG_ACTIVE_LOW(1'b1)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .wrap(wrap), .load(load), .load_value(lv4[0:0]),
        .count(c3), .seg(s3), .rollover(r3), .at_limit(a3));

    assign dc[0] = {1'b0, c0};
    assign dc[1] = c1;
    assign dc[2] = c2;
    assign dc[3] = {3'b000, c3};
    assign ds[0] = s0;
    assign ds[1] = s1;
    assign ds[2] = s2;
    assign ds[3] = s3;
    assign dr[0] = r0;
    assign dr[1] = r1;
    assign dr[2] = r2;
    assign dr[3] = r3;
    assign da[0] = a0;
    assign da[1] = a1;
    assign da[2] = a2;
    assign da[3] = a3;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the counter as a number in 0..M-1 obeying the rules.
    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mcnt[i]  <= 0;
                mroll[i] <= 1'b0;
            end else if (load) begin
                mcnt[i] <= (int'(lv4) % (1 << WS[i]) >= MODS[i])
                           ? MODS[i] - 1
                           : int'(lv4) % (1 << WS[i]);
                mroll[i] <= 1'b0;
            end else if (enable && up) begin
                if (mcnt[i] < MODS[i] - 1) begin
                    mcnt[i]  <= mcnt[i] + 1;
                    mroll[i] <= 1'b0;
                end else begin
                    mcnt[i]  <= wrap ? 0 : mcnt[i];
                    mroll[i] <= wrap;
                end
            end else if (enable) begin
                if (mcnt[i] > 0) begin
                    mcnt[i]  <= mcnt[i] - 1;
                    mroll[i] <= 1'b0;
                end else begin
                    mcnt[i]  <= wrap ? MODS[i] - 1 : 0;
                    mroll[i] <= wrap;
                end
            end else begin
                mroll[i] <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("count[%0d]", i), 32'(dc[i]), mcnt[i]);
            chk($sformatf("seg[%0d]", i), 32'(ds[i]),
                32'(GLY[mcnt[i]] ^ (AL[i] ? 7'h7F : 7'h00)));
            chk($sformatf("rollover[%0d]", i), 32'(dr[i]),
                32'(mroll[i]));
            chk($sformatf("at_limit[%0d]", i), 32'(da[i]),
                up ? 32'(mcnt[i] == MODS[i] - 1) : 32'(mcnt[i] == 0));
        end
    end

    task automatic edge1();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    int e33 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int e38 [4]  = '{1, 0, 1, 0};

    initial begin
        #1;
        chk("reset count0", 32'(c0), 0);
        chk("reset seg0", 32'(s0), 32'h3F);
        chk("reset seg3 low", 32'(s3), 32'h40);
        chk("reset limit up", 32'(a1), 0);
        @(negedge clock);
        #1 reset = 1'b0;

        do_reset();
        enable = 1'b1; up = 1'b1; wrap = 1'b1; load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge1();
            chk("wrap8 count", 32'(c0), e33[k]);
            chk("wrap8 roll", 32'(r0), 32'(k == 7));
            if (k == 0) chk("wrap8 seg1", 32'(s0), 32'h06);
        end

        do_reset();
        up = 1'b0; wrap = 1'b0; enable = 1'b1;
        #1 chk("sat10 limit0", 32'(a1), 1);
        for (int k = 0; k < 3; k++) begin
            edge1();
            chk("sat10 count", 32'(c1), 0);
            chk("sat10 roll", 32'(r1), 0);
            chk("sat10 limit", 32'(a1), 1);
        end

        load = 1'b1; lv4 = 4'd13; enable = 1'b0;
        edge1();
        chk("load13 clamp", 32'(c1), 9);
        load = 1'b0; enable = 1'b1; up = 1'b1; wrap = 1'b1;
        edge1();
        chk("clamp wrap count", 32'(c1), 0);
        chk("clamp wrap roll", 32'(r1), 1);
        edge1();
        chk("roll one cycle", 32'(r1), 0);

        load = 1'b1; lv4 = 4'd5; enable = 1'b1; up = 1'b1;
        edge1();
        chk("load beats inc", 32'(c2), 5);

        lv4 = 4'd6; enable = 1'b0;
        edge1();
        chk("load6", 32'(c0), 6);
        load = 1'b0;
        reset = 1'b1;
        #1;
        chk("async rst count", 32'(c0), 0);
        chk("async rst seg", 32'(s0), 32'h3F);
        chk("async rst seg low", 32'(s3), 32'h40);
        up = 1'b0;
        #1 chk("rst limit down", 32'(a0), 1);
        reset = 1'b0;

        do_reset();
        up = 1'b0; wrap = 1'b1; enable = 1'b1; load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge1();
            chk("mod2 count", 32'(c3), e38[k]);
            chk("mod2 roll", 32'(r3), 32'(k % 2 == 0));
        end

        for (int n = 0; n < 600; n++) begin
            enable = ($urandom_range(0, 3) != 0);
            up     = 1'($urandom_range(0, 1));
            wrap   = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 7) == 0);
            lv4    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            edge1();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/configurable_state_counter.md
CONFIGURABLE_STATE_COUNTER -- requirements
Module: configurable_state_counter

Interface
REQ-001 Parameter MODULUS, default 8, number of count states (legal 2..16); SHALL be rejected at elaboration outside that range.
REQ-002 Parameter SEG_ACTIVE_LOW, default 0, 1 = inverted segment drive for common-anode displays.
REQ-003 Localparam W = clog2(MODULUS), minimum 1; SHALL be derived, not user-set.
REQ-004 clock  input  1  single rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  count step qualifier.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 wrap  input  1  mode: 1 = wrap-around, 0 = saturate at limits.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_value  input  W  value captured on load.
REQ-011 count  output  W  current state, registered.
REQ-012 seg  output  7  seven-segment pattern of count, bit 0 = segment a ... bit 6 = segment g.
REQ-013 rollover  output  1  registered one-cycle pulse marking a wrap event.
REQ-014 at_limit  output  1  high while count equals the limit in the current direction (MODULUS-1 if up, 0 if down).

Function
REQ-015 Per rising edge, priority SHALL be: reset > load > enable > hold.
REQ-016 load=1: count <= load_value if load_value < MODULUS, else MODULUS-1; rollover <= 0; enable and up ignored.
REQ-017 load=0, enable=1, up=1, count < MODULUS-1: count <= count+1.
REQ-018 load=0, enable=1, up=0, count > 0: count <= count-1.
REQ-019 Up at MODULUS-1 with wrap=1: count <= 0, rollover <= 1 for the following cycle only.
REQ-020 Down at 0 with wrap=1: count <= MODULUS-1, rollover <= 1 for the following cycle only.
REQ-021 Limit reached with wrap=0: count holds, rollover <= 0.
REQ-022 enable=0 and load=0: count holds, rollover <= 0.
REQ-023 Arithmetic SHALL be W bits; count SHALL never reach a value >= MODULUS.
REQ-024 seg SHALL be a combinational decode of count (hex glyphs 0-9, A-F), zero added latency; inverted when SEG_ACTIVE_LOW=1.
REQ-025 at_limit SHALL be combinational from count and up; changing up mid-stream SHALL update at_limit in the same cycle.
REQ-026 Changing wrap or up between edges SHALL only affect the next edge; no state retained from prior mode.

Reset
REQ-027 reset=1 SHALL immediately force count=0 and rollover=0, independent of clock.
REQ-028 During reset, seg SHALL show glyph "0" and at_limit SHALL equal ~up.
REQ-029 Reset asserted mid-count or mid-load SHALL discard the pending update; first edge after release SHALL operate normally.

Structure
REQ-030 Shared package counter_pkg SHALL hold the 16-entry segment glyph table and segment index constants (SEG_A..SEG_G).
REQ-031 Decoder SHALL be sub-module hex_to_seven_segment (4-bit in, 7-bit out, polarity parameter), count zero-extended to 4 bits.
REQ-032 Next-state logic and state register SHALL remain in configurable_state_counter; no gated clocks.

Verification
REQ-033 MODULUS=8, wrap=1, up=1, enable=1, 10 edges from reset -> count 1..7,0,1,2; rollover high exactly one cycle after the 7->0 edge; seg 0x06 at count 1.
REQ-034 MODULUS=10, wrap=0, up=0 from reset, 3 edges -> count stays 0, rollover never high, at_limit=1 throughout.
REQ-035 MODULUS=10, load=1 load_value=13 -> count=9; next edge up, wrap=1 -> count=0, rollover pulse.
REQ-036 MODULUS=16, load=1 and enable=1 same edge with load_value=5 -> count=5 (load wins, no increment).
REQ-037 Count at 6, assert reset between edges -> count=0 and seg=0x3F before next edge; SEG_ACTIVE_LOW=1 run -> seg=0x40.
REQ-038 MODULUS=2, wrap=1, down, enable=1 -> count alternates 1,0,1,0; rollover pulse after each 0->1 edge only.
